// File: rtl/fft_agu_pkg.sv
// Shared types and address helpers for the radix-2 DIT FFT address generator.
package fft_agu_pkg;

  // Default transform size: 2**5 = 32 points.
  localparam int N_2_DEF = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CALC   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  // Number of butterflies per stage (also the number of load/unload pairs).
  function automatic int half_points(input int n2);
    return 1 << (n2 - 1);
  endfunction

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < w) r[w-1-k] = v[k];
    end
    return r;
  endfunction

  // Rotate the low w bits of v left by sh (0 <= sh < w).
  function automatic logic [15:0] rotl(input logic [15:0] v, input int sh, input int w);
    logic [15:0] mask;
    mask = (16'd1 << w) - 16'd1;
    return ((v << sh) | ((v & mask) >> (w - sh))) & mask;
  endfunction

endpackage

// File: rtl/fft_agu.sv
// Address generator and phase sequencer for an in-place radix-2 DIT FFT.
// Outputs are decoded combinationally from state and counters, so they follow
// an asynchronous reset immediately and line up with asynchronous RAM reads.
//
//  state  | meaning
//  IDLE   | waiting for start, all outputs low
//  LOAD   | accepting input pairs, written at bit-reversed addresses
//  CALC   | one butterfly per cycle, N_2 stages of N/2 butterflies
//  UNLOAD | presenting result pairs in natural order
module fft_agu
  import fft_agu_pkg::*;
#(
  parameter int N_2 = N_2_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           load_valid,
  output logic           load_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_2-1:0] adra,
  output logic [N_2-1:0] adrb,
  output logic           we,
  output logic           wd_sel,
  output logic [N_2-2:0] twiddle_adr,
  output logic           busy,
  output logic           done
);

  localparam int JW = N_2 - 1;
  localparam int IW = (N_2 > 2) ? $clog2(N_2) : 1;
  localparam int HALF = half_points(N_2);

  state_t        state;
  logic [JW-1:0] j;
  logic [IW-1:0] i;

  logic          last_j;
  logic          last_i;
  logic [15:0]   pair_a;
  logic [15:0]   pair_b;
  logic [15:0]   low_mask;

  assign last_j = (j == JW'(HALF - 1));
  assign last_i = (i == IW'(N_2 - 1));
  assign pair_a = 16'({j, 1'b0});
  assign pair_b = 16'({j, 1'b1});

  // Phase sequencing and pair/butterfly/stage counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      j     <= '0;
      i     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            j     <= '0;
            i     <= '0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            if (last_j) begin
              state <= CALC;
              j     <= '0;
              i     <= '0;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        CALC: begin
          j <= j + 1'b1;
          if (last_j) begin
            if (last_i) begin
              state <= UNLOAD;
              i     <= '0;
            end else begin
              i <= i + 1'b1;
            end
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            j <= j + 1'b1;
            if (last_j) state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          j     <= '0;
          i     <= '0;
        end
      endcase
    end
  end

  // Address, write-enable and handshake decode for the current phase.
  always_comb begin
    load_ready  = 1'b0;
    out_valid   = 1'b0;
    adra        = '0;
    adrb        = '0;
    we          = 1'b0;
    wd_sel      = 1'b0;
    twiddle_adr = '0;
    busy        = 1'b0;
    done        = 1'b0;
    // Clears the low (N_2-1-i) bits of j; stage 0 masks everything, last stage nothing.
    low_mask    = (16'd1 << (JW - int'(i))) - 16'd1;
    case (state)
      LOAD: begin
        busy       = 1'b1;
        load_ready = 1'b1;
        we         = load_valid;
        adra       = N_2'(bitrev(pair_a, N_2));
        adrb       = N_2'(bitrev(pair_b, N_2));
      end
      CALC: begin
        busy        = 1'b1;
        we          = 1'b1;
        wd_sel      = 1'b1;
        adra        = N_2'(rotl(pair_a, int'(i), N_2));
        adrb        = N_2'(rotl(pair_b, int'(i), N_2));
        twiddle_adr = j & ~low_mask[JW-1:0];
      end
      UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        adra      = N_2'(pair_a);
        adrb      = N_2'(pair_b);
        done      = out_ready & last_j;
      end
      default: begin
      end
    endcase
  end

endmodule
